// File: rtl/pipeline_driver.sv
`default_nettype none
// ============================================================================
// pipeline_driver
//   LFSR stimulus driver and self-checker for enable-gated register pipelines.
//   Revision: 1.0
// ============================================================================
module pipeline_driver #(
    parameter int          WIDTH       = 8,
    parameter int          DEPTH       = 2,
    parameter int          NUM_VECTORS = 16,
    parameter logic [15:0] SEED        = 16'h0009
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic             en,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [15:0]      err_step,
    output logic [WIDTH-1:0] err_got,
    output logic [WIDTH-1:0] err_exp
);

    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_STEP  = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_mismatch;
    logic [15:0]      r_lfsr;
    logic [15:0]      w_lfsr_nxt;
    logic [15:0]      r_step;
    logic [15:0]      w_step_inc;
    logic [3:0]       r_drain;
    logic [WIDTH-1:0] r_model [DEPTH];
    logic [WIDTH-1:0] w_model_out;

    assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_step_inc  = r_step + 16'd1;
    assign w_model_out = r_model[DEPTH-1];
    // Both y and the model are pre-edge values, so they line up with the DUT.
    assign w_mismatch  = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (y != w_model_out);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_mismatch) begin
                    w_state_nxt = S_DONE;
                end else if (r_step == LAST_STEP) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_mismatch || (r_drain == LAST_DRAIN)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a        <= '0;
            en       <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_step <= '0;
            err_got  <= '0;
            err_exp  <= '0;
            r_lfsr   <= SEED_EFF;
            r_step   <= '0;
            r_drain  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_model[i] <= '0;
            end
        end else begin
            // Expected-output model mirrors the DUT contract: shift on driven en.
            if (w_load) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_model[i] <= '0;
                end
            end else if (en) begin
                r_model[0] <= a;
                for (int i = 1; i < DEPTH; i++) begin
                    r_model[i] <= r_model[i-1];
                end
            end

            if (w_load) begin
                a        <= SEED_EFF[WIDTH-1:0];
                en       <= 1'b1;
                r_lfsr   <= SEED_EFF;
                r_step   <= '0;
                r_drain  <= '0;
                pass     <= 1'b0;
                fail     <= 1'b0;
                err_step <= '0;
                err_got  <= '0;
                err_exp  <= '0;
            end else if (w_mismatch) begin
                a        <= '0;
                en       <= 1'b0;
                fail     <= 1'b1;
                err_step <= r_step;
                err_got  <= y;
                err_exp  <= w_model_out;
            end else if (r_state == S_RUN) begin
                r_lfsr <= w_lfsr_nxt;
                r_step <= w_step_inc;
                if (r_step == LAST_STEP) begin
                    a       <= '0;
                    en      <= 1'b1;
                    r_drain <= '0;
                end else begin
                    a  <= w_lfsr_nxt[WIDTH-1:0];
                    en <= (w_step_inc[1:0] != 2'd3);
                end
            end else if (r_state == S_DRAIN) begin
                if (r_drain == LAST_DRAIN) begin
                    a    <= '0;
                    en   <= 1'b0;
                    pass <= 1'b1;
                end else begin
                    r_drain <= r_drain + 4'd1;
                    r_step  <= w_step_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_driver.sv
`default_nettype none
// ============================================================================
// tb_pipeline_driver
//   Bench for pipeline_driver with a behavioural pipeline DUT and fault modes.
//   Revision: 1.0
// ============================================================================
module tb_pipeline_driver;

    localparam int NV    = 16;
    localparam int DEPTH = 2;

    logic        clk, rst, start;
    logic [7:0]  a, y, err_got, err_exp;
    logic        en, busy, done, pass, fail;
    logic [15:0] err_step;

    logic        s_start, s_en, s_busy, s_done, s_pass, s_fail;
    logic [3:0]  s_a, s_y, s_err_got, s_err_exp;
    logic [15:0] s_err_step;

    int          tests = 0;
    int          fails = 0;
    int          mode;        // 0 ideal, 1 ignores en, 2 y[0] stuck 0, 3 inject mask
    int          inj_step;
    logic [7:0]  inj_mask;
    int          cnt;
    logic [7:0]  pipe0, pipe1;
    logic [3:0]  s_pipe;

    pipeline_driver #(.WIDTH(8), .DEPTH(DEPTH), .NUM_VECTORS(NV), .SEED(16'h0009)) dut (
        .clock(clk), .reset(rst), .start(start), .a(a), .en(en), .y(y),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .err_step(err_step), .err_got(err_got), .err_exp(err_exp)
    );

    pipeline_driver #(.WIDTH(4), .DEPTH(1), .NUM_VECTORS(1), .SEED(16'h0000)) dut_s (
        .clock(clk), .reset(rst), .start(s_start), .a(s_a), .en(s_en), .y(s_y),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
        .err_step(s_err_step), .err_got(s_err_got), .err_exp(s_err_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline under test, plus a step counter used to place injected faults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe0 <= 8'h00; pipe1 <= 8'h00; s_pipe <= 4'h0; cnt <= 0;
        end else begin
            if (en || mode == 1) begin pipe0 <= a; pipe1 <= pipe0; end
            if (s_en) s_pipe <= s_a;
            if (start && !busy) cnt <= 0;
            else if (busy) cnt <= cnt + 1;
        end
    end

    always_comb begin
        y = pipe1;
        if (mode == 2) y[0] = 1'b0;
        if (mode == 3 && busy && cnt == inj_step) y = y ^ inj_mask;
    end
    assign s_y = s_pipe;

    typedef struct {
        int mode; int inj; logic [7:0] mask; int start_at; bit pre_rst;
        bit ok; logic [15:0] estep; logic [7:0] egot; logic [7:0] eexp; int ebusy;
    } vec_t;
    typedef struct { bit ok; logic [15:0] step; logic [7:0] got; logic [7:0] expv; int nbusy; } res_t;

    function automatic logic [15:0] lfsr_at(int k);
        logic [15:0] l;
        l = 16'h0009;
        for (int i = 0; i < k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
    endfunction

    // DUT output during step k: the value DEPTH enabled shifts back.
    function automatic logic [7:0] model_y(int k, bit ign);
        logic [7:0] q[$];
        logic [15:0] l;
        logic [7:0] v;
        bit e;
        for (int j = 0; j < k; j++) begin
            if (j < NV) begin l = lfsr_at(j); v = l[7:0]; e = (j % 4) != 3; end
            else begin v = 8'h00; e = 1'b1; end
            if (e || ign) q.push_back(v);
        end
        return (q.size() >= DEPTH) ? q[q.size() - DEPTH] : 8'h00;
    endfunction

    function automatic res_t predict(int m, int inj, logic [7:0] msk);
        res_t r;
        logic [7:0] ye, yd;
        r.ok = 1'b1; r.step = 16'd0; r.got = 8'h00; r.expv = 8'h00; r.nbusy = NV + DEPTH + 1;
        for (int k = 0; k < NV + DEPTH + 1; k++) begin
            ye = model_y(k, 1'b0);
            yd = model_y(k, m == 1);
            if (m == 2) yd[0] = 1'b0;
            if (m == 3 && k == inj) yd = yd ^ msk;
            if (yd != ye) begin
                r.ok = 1'b0; r.step = 16'(k); r.got = yd; r.expv = ye; r.nbusy = k + 1;
                break;
            end
        end
        return r;
    endfunction

    task automatic check(string nm, logic [31:0] got, logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, expv);
        end
    endtask

    task automatic check_idle(string tag);
        check({tag, "_outs"}, 32'({a, en, busy, done, pass, fail}), 32'd0);
        check({tag, "_errs"}, {err_step, err_got, err_exp}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic run_one(input int start_at, output int nbusy, output int bad_step);
        logic [15:0] l;
        logic [7:0]  ea;
        logic        ee;
        nbusy = 0; bad_step = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (busy === 1'b1 && nbusy < 200) begin
            if (nbusy < NV) begin l = lfsr_at(nbusy); ea = l[7:0]; ee = (nbusy % 4) != 3; end
            else begin ea = 8'h00; ee = 1'b1; end
            if (bad_step < 0 && (a !== ea || en !== ee || done !== 1'b0 ||
                                 pass !== 1'b0 || fail !== 1'b0))
                bad_step = nbusy;
            nbusy++;
            start = (nbusy == start_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_result(string tag, int nb, int bs, bit ok, logic [15:0] es,
                                logic [7:0] eg, logic [7:0] ee, int ebusy);
        check({tag, "_busy_cycles"}, nb, ebusy);
        check({tag, "_a_en_seq_bad_step"}, bs, -1);
        check({tag, "_done_pass_fail"}, {done, pass, fail}, {1'b1, ok, !ok});
        check({tag, "_err_step"}, err_step, es);
        check({tag, "_err_got"}, err_got, eg);
        check({tag, "_err_exp"}, err_exp, ee);
        check({tag, "_a_en_after"}, {a, en}, 9'd0);
    endtask

    vec_t tbl [8];

    initial begin
        int nb, bs, n;
        res_t p;
        rst = 1'b1; start = 1'b0; s_start = 1'b0;
        mode = 0; inj_step = -1; inj_mask = 8'h00;

        tbl[0] = '{0, -1, 8'h00,  5, 1'b0, 1'b1, 16'd0,  8'h00, 8'h00, 19};
        tbl[1] = '{0, -1, 8'h00, -1, 1'b0, 1'b1, 16'd0,  8'h00, 8'h00, 19};
        tbl[2] = '{3, 17, 8'hFF, -1, 1'b0, 1'b0, 16'd17, 8'hAE, 8'h51, 18};
        tbl[3] = '{0, -1, 8'h00, -1, 1'b0, 1'b1, 16'd0,  8'h00, 8'h00, 19};
        tbl[4] = '{1, -1, 8'h00, -1, 1'b0, 1'b0, 16'd4,  8'h24, 8'h12, 5};
        tbl[5] = '{2, -1, 8'h00, -1, 1'b1, 1'b0, 16'd2,  8'h08, 8'h09, 3};
        tbl[6] = '{3,  0, 8'h80, -1, 1'b1, 1'b0, 16'd0,  8'h80, 8'h00, 1};
        tbl[7] = '{3, 18, 8'h01, -1, 1'b1, 1'b0, 16'd18, 8'h01, 8'h00, 19};

        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre_rst) pulse_reset();
            @(negedge clk);
            mode = tbl[i].mode; inj_step = tbl[i].inj; inj_mask = tbl[i].mask;
            run_one(tbl[i].start_at, nb, bs);
            check_result($sformatf("row%0d", i), nb, bs, tbl[i].ok, tbl[i].estep,
                         tbl[i].egot, tbl[i].eexp, tbl[i].ebusy);
        end

        // Asynchronous reset while holding a captured failure.
        #2 rst = 1'b1;
        #1 check_idle("async_reset_done");
        @(negedge clk); rst = 1'b0;

        // Reset during step 7, then the same sequence must replay cleanly.
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        check("step7_a_en", {a, en}, {8'h80, 1'b0});
        check("step7_busy", busy, 1'b1);
        rst = 1'b1;
        #1 check_idle("reset_mid_run");
        @(negedge clk); rst = 1'b0;
        run_one(-1, nb, bs);
        check_result("rerun", nb, bs, 1'b1, 16'd0, 8'h00, 8'h00, NV + DEPTH + 1);

        for (int r = 0; r < 6; r++) begin
            int          inj, sa;
            logic [7:0]  msk;
            inj = $urandom_range(0, NV + DEPTH);
            msk = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            sa  = $urandom_range(1, 16);
            p   = predict(3, inj, msk);
            pulse_reset();
            repeat ($urandom_range(0, 4)) @(negedge clk);
            mode = 3; inj_step = inj; inj_mask = msk;
            run_one(sa, nb, bs);
            check_result($sformatf("rnd%0d_inj%0d_m%0h", r, inj, msk), nb, bs,
                         p.ok, p.step, p.got, p.expv, p.nbusy);
        end

        // Minimal configuration: zero seed, one vector, one stage.
        pulse_reset();
        mode = 0;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        check("small_first_a_en", {s_a, s_en}, {4'h1, 1'b1});
        n = 0;
        while (s_busy === 1'b1 && n < 50) begin n++; @(negedge clk); end
        check("small_busy_cycles", n, 3);
        check("small_done_pass_fail", {s_done, s_pass, s_fail}, 3'b110);
        check("small_errs", {s_err_step, s_err_got, s_err_exp}, 24'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pipeline_driver.md
# pipeline_driver

Self-checking hardware stimulus generator and response checker for enable-gated register pipelines. It is the driving end of a pipeline's `a`/`en` → `y` interface. It runs a pseudo-random vector sequence into the DUT and models the expected output internally. It compares every cycle and reports pass/fail with first-error capture, so pipeline blocks can be validated on-board without a simulator.

## Interface
- `WIDTH`, 8: data width of `a`/`y`; legal 1..16.
- `DEPTH`, 2: number of enabled registers between `a` and `y` in the DUT; legal 1..8.
- `NUM_VECTORS`, 16: vectors driven per run; legal 1..65535.
- `SEED`, 16'h0009: LFSR seed; 0 is replaced by 16'h0001.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: begin a run; sampled in IDLE and DONE only.
- `a` out WIDTH: stimulus data to DUT (registered).
- `en` out 1: stimulus enable to DUT (registered).
- `y` in WIDTH: DUT output.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when no mismatch occurred.
- `fail` out 1: high in DONE after a mismatch.
- `err_step` out 16: step index of the first mismatch.
- `err_got` out WIDTH: `y` value at the first mismatch.
- `err_exp` out WIDTH: model value at the first mismatch.

## Operation
- DUT contract: `DEPTH` registers in series, all clocked with enable `en`, all reset to 0; `y` = last stage.
- Reset values: state IDLE; `a`=0, `en`=0, `busy`=0, `done`=0, `pass`=0, `fail`=0; `err_*`=0; model stages=0; LFSR=SEED; step=0.
- LFSR, 16-bit Fibonacci: fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}. Stimulus `a` = l[WIDTH-1:0].
- Model: `DEPTH`-stage shift register. On every rising edge where the driven `en`=1, it shifts in the driven `a`. `model_out` = last stage.
- States:
  - IDLE --start--> RUN; the LFSR is loaded with SEED and step is cleared.
  - RUN: drives step k with `a`=lfsr_k and `en`=(k[1:0]!=3). The LFSR advances every RUN cycle. After step NUM_VECTORS-1 → DRAIN.
  - DRAIN: `a`=0, `en`=1, for DEPTH+1 cycles → DONE.
  - DONE: holds results. `start` → RUN (clears pass/fail/err_*, reseeds the LFSR, step=0, clears the model).
- Check: on each edge in RUN or DRAIN, compare `y` to `model_out` (both pre-edge values).
  - Mismatch → next state DONE with `fail`=1, `a`=0, `en`=0.
  - `err_step` = current step; DRAIN cycles count on as NUM_VECTORS, NUM_VECTORS+1, …
  - `err_got` = `y`; `err_exp` = `model_out`.
- Only the first mismatch is captured.
- `pass` is set on a normal DRAIN→DONE exit. `pass` and `fail` are never both 1.
- `start` is ignored while busy.

## Timing
- Start latency: `start` high at edge E0 in IDLE → RUN from E0. First vector (`a`=SEED[WIDTH-1:0], `en`=1) is visible after E0.
- Run length: `busy` high for exactly NUM_VECTORS+DEPTH+1 cycles on a clean run; `done`/`pass` rise on the following edge.
- Fail latency: mismatch sampled at edge En → `fail`=1, `done`=1, `busy`=0 after En.
- Reset mid-run: all outputs return to reset values immediately, without waiting for a clock edge. The next run reproduces the identical sequence.
- Checking uses only registered outputs.
- `y` is sampled directly: the DUT must share `clock` and `reset`, with no added latency beyond DEPTH.

## Test plan
- Ideal DUT (DEPTH=2 enabled regs, WIDTH=8, NUM_VECTORS=16):
  - pulse `start` → `busy` high 19 cycles, then `pass`=1, `fail`=0, `done`=1.
  - `a` sequence begins 0x09 and follows the LFSR; `en` pattern 1,1,1,0 repeating.
- DUT ignoring `en` (DEPTH=2) → `fail`=1 with `err_step`=4, `err_got`=lfsr_2[7:0], `err_exp`=lfsr_1[7:0]; `en`=0 and `a`=0 after detection.
- DUT with `y[0]` stuck at 0 → `fail` at the first step where `model_out[0]`=1; `err_exp`^`err_got` = 8'h01.
- `reset` asserted at step 7 of a run → all outputs zero at once. After release, `start` → clean pass with the same `a` sequence from 0x09.
- `start` pulsed during RUN → ignored, single run completes. `start` in DONE → results cleared, and an identical second run passes.
- SEED=0, WIDTH=4, DEPTH=1, NUM_VECTORS=1 → first `a`=4'h1; `busy` high 3 cycles; `pass`=1.
